// File: rtl/avalon_ram_ws_pkg.sv
// Shared types and helpers for the wait-state Avalon-MM RAM model.
// Covers the wait-mode selector, FSM states, reset vector and byte-lane swap helpers.
package avalon_ram_pkg;

    typedef enum logic [1:0] {
        WAIT_NONE   = 2'd0,
        WAIT_FIXED  = 2'd1,
        WAIT_RANDOM = 2'd2
    } wait_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // Bus lane k <-> stored byte (3-k): big-endian file image on a little-endian lane map
    function automatic logic [31:0] lane_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [3:0] be_swap(input logic [3:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/avalon_ram_ws_if.sv
// Avalon-MM bus bundle between a master (CPU/testbench) and the RAM slave.
interface avalon_ram_ws_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        error;

    modport master (
        output address, byteenable, write, read, writedata,
        input  waitrequest, readdata, readdatavalid, error
    );

    modport slave (
        input  address, byteenable, write, read, writedata,
        output waitrequest, readdata, readdatavalid, error
    );
endinterface

// File: rtl/avalon_ram_ws_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used to draw pseudo-random wait counts.
module ram_wait_lfsr (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    logic feedback;

    assign feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= seed;
        end else if (advance) begin
            value <= {feedback, value[15:1]};
        end
    end
endmodule

// File: rtl/avalon_ram_ws.sv
// Avalon-MM slave RAM with configurable base/depth, lane ordering, wait-state injection,
// one-cycle read latency and out-of-range / read+write error pulses.
module avalon_ram_ws
    import avalon_ram_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] BASE_ADDR     = RESET_VECTOR,
    parameter int          DEPTH_WORDS   = 65536,
    parameter int          WAIT_MODE     = 0,
    parameter int          WAIT_CYCLES   = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter bit          BYTE_SWAP     = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    avalon_ram_ws_if.slave    bus
);
    localparam int         AW   = $clog2(DEPTH_WORDS);
    localparam wait_mode_e MODE = wait_mode_e'(WAIT_MODE[1:0]);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  n_wait;
    logic [15:0] lfsr_val;
    logic        unused_lfsr_hi;
    logic        req, accept, advance, wait_req;

    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] mem_idx;
    logic [31:0] wr_data, rd_word, rd_lanes;
    logic [3:0]  wr_be;
    logic        rd_only;

    logic [31:0] rdata_p1;
    logic        rvld_p1, err_p1;

    ram_wait_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance),
        .seed    (LFSR_SEED),
        .value   (lfsr_val)
    );

    assign unused_lfsr_hi = ^lfsr_val[15:4];
    assign req            = bus.read | bus.write;
    assign rd_only        = bus.read & ~bus.write;

    // Wrap-around subtraction: addresses below the base land far out of range
    assign offset   = bus.address - BASE_ADDR;
    assign in_range = {1'b0, offset} < (33'(DEPTH_WORDS) << 2);
    assign mem_idx  = offset[AW+1:2];

    assign wr_data  = BYTE_SWAP ? lane_swap(bus.writedata) : bus.writedata;
    assign wr_be    = BYTE_SWAP ? be_swap(bus.byteenable) : bus.byteenable;
    assign rd_word  = BYTE_SWAP ? lane_swap(mem[mem_idx]) : mem[mem_idx];
    assign rd_lanes = rd_word & {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                                 {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

    always_comb begin
        case (MODE)
            WAIT_FIXED:  n_wait = 4'(WAIT_CYCLES);
            WAIT_RANDOM: n_wait = 4'({28'd0, lfsr_val[3:0]} % 32'(WAIT_CYCLES + 1));
            default:     n_wait = 4'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_req = 1'b0;
        accept   = 1'b0;
        advance  = 1'b0;
        if (!reset_n) begin
            wait_req = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        advance = 1'b1;
                        if (n_wait == 4'd0) begin
                            accept = 1'b1;
                        end else begin
                            wait_req = 1'b1;
                            cnt_d    = n_wait;
                            state_d  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else if (cnt_q > 4'd1) begin
                        wait_req = 1'b1;
                        cnt_d    = cnt_q - 4'd1;
                    end else begin
                        accept  = 1'b1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.waitrequest = wait_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.write && in_range) begin
            for (int j = 0; j < 4; j++) begin
                if (wr_be[j]) mem[mem_idx][8*j +: 8] <= wr_data[8*j +: 8];
            end
        end
    end

    // p1: registered read response and error pulse, one cycle after acceptance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_p1 <= 32'd0;
            rvld_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            rvld_p1 <= accept & rd_only;
            err_p1  <= accept & (~in_range | (bus.read & bus.write));
            if (accept && rd_only) rdata_p1 <= in_range ? rd_lanes : 32'd0;
        end
    end

    assign bus.readdata      = rdata_p1;
    assign bus.readdatavalid = rvld_p1;
    assign bus.error         = err_p1;

endmodule
